// File: rtl/fios_mm_sequencer.sv
// Control sequencer for a word-serial FIOS Montgomery multiplier.
// It accepts tagged requests, steps the operand/result RAM addresses, and reports completion with an error flag.
//
// state | meaning
// IDLE  | ready for a request; holds last addresses
// START | one-cycle start pulse; clears counters and watchdog
// RUN   | follows multiplier strobes; watchdog counting
// RESP  | response presented until resp_ready_i
module fios_mm_sequencer #(
    parameter int s       = 8,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                                clock_i,
    input  logic                                reset_n_i,
    input  logic                                req_valid_i,
    input  logic [TAG_W-1:0]                    req_tag_i,
    output logic                                req_ready_o,
    output logic                                start_o,
    input  logic                                b_fetch_i,
    input  logic                                p_fetch_i,
    input  logic                                a_shift_i,
    input  logic                                res_push_i,
    input  logic                                done_i,
    output logic [((s > 1) ? $clog2(s) : 1)-1:0] b_addr_o,
    output logic [((s > 1) ? $clog2(s) : 1)-1:0] p_addr_o,
    output logic [((s > 1) ? $clog2(s) : 1)-1:0] a_cnt_o,
    output logic                                res_we_o,
    output logic [((s > 1) ? $clog2(s) : 1)-1:0] res_addr_o,
    output logic                                resp_valid_o,
    output logic [TAG_W-1:0]                    resp_tag_o,
    output logic                                resp_err_o,
    input  logic                                resp_ready_i,
    output logic                                busy_o
);

    localparam int AW = (s > 1) ? $clog2(s) : 1;
    localparam int CW = $clog2(s + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LAST   = AW'(s - 1);
    localparam logic [CW-1:0] FULL   = CW'(s);
    // Abort once the watchdog is about to reach TIMEOUT-1.
    localparam logic [WW-1:0] WD_LIM = WW'(TIMEOUT - 2);

    typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_b_addr;
    logic [AW-1:0]   r_p_addr;
    logic [AW-1:0]   r_a_cnt;
    logic [CW-1:0]   r_res_cnt;
    logic            r_ovf;
    logic [WW-1:0]   r_wd;
    logic [TAG_W-1:0] r_tag;
    logic            r_err;

    logic            w_run;
    logic            w_push_ok;
    logic            w_push_ovf;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_ovf_nxt;
    logic            w_timeout;

    assign w_run      = (r_state == RUN);
    assign w_push_ok  = w_run & res_push_i & (r_res_cnt != FULL);
    assign w_push_ovf = w_run & res_push_i & (r_res_cnt == FULL);
    assign w_cnt_nxt  = w_push_ok ? (r_res_cnt + CW'(1)) : r_res_cnt;
    assign w_ovf_nxt  = r_ovf | w_push_ovf;
    assign w_timeout  = (r_wd == WD_LIM);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= IDLE;
            r_b_addr  <= '0;
            r_p_addr  <= '0;
            r_a_cnt   <= '0;
            r_res_cnt <= '0;
            r_ovf     <= 1'b0;
            r_wd      <= '0;
            r_tag     <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_tag   <= req_tag_i;
                        r_state <= START;
                    end
                end
                START: begin
                    r_b_addr  <= '0;
                    r_p_addr  <= '0;
                    r_a_cnt   <= '0;
                    r_res_cnt <= '0;
                    r_ovf     <= 1'b0;
                    r_wd      <= '0;
                    r_err     <= 1'b0;
                    r_state   <= RUN;
                end
                RUN: begin
                    if (b_fetch_i)
                        r_b_addr <= (r_b_addr == LAST) ? '0 : r_b_addr + AW'(1);
                    if (p_fetch_i)
                        r_p_addr <= (r_p_addr == LAST) ? '0 : r_p_addr + AW'(1);
                    if (a_shift_i && (r_a_cnt != LAST))
                        r_a_cnt <= r_a_cnt + AW'(1);
                    r_res_cnt <= w_cnt_nxt;
                    r_ovf     <= w_ovf_nxt;
                    r_wd      <= r_wd + WW'(1);
                    // done_i wins over a coincident timeout; this cycle's push counts.
                    if (done_i) begin
                        r_err   <= (w_cnt_nxt != FULL) | w_ovf_nxt;
                        r_state <= RESP;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = (r_state == IDLE);
    assign start_o      = (r_state == START);
    assign busy_o       = (r_state != IDLE);
    assign b_addr_o     = r_b_addr;
    assign p_addr_o     = r_p_addr;
    assign a_cnt_o      = r_a_cnt;
    assign res_we_o     = w_push_ok;
    assign res_addr_o   = AW'(r_res_cnt);
    assign resp_valid_o = (r_state == RESP);
    assign resp_tag_o   = r_tag;
    assign resp_err_o   = r_err;

endmodule

// File: doc/fios_mm_sequencer.md
FIOS_MM_SEQUENCER -- requirements
Module: fios_mm_sequencer

Interface
REQ-001 SHALL have parameter s, default 8: number of 17-bit words per operand; s >= 2.
REQ-002 SHALL have parameter TAG_W, default 4: width of the request/response tag.
REQ-003 SHALL have parameter TIMEOUT, default 4096: maximum number of RUN cycles before abort.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clock_i, input, 1, the sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n_i, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid_i, input, 1, a multiplication request is pending.
REQ-008 SHALL have port req_tag_i, input, TAG_W, the request identifier.
REQ-009 SHALL have port req_ready_o, output, 1, the sequencer can accept a request.
REQ-010 SHALL have port start_o, output, 1, one-cycle start pulse to the FIOS multiplier.
REQ-011 SHALL have ports b_fetch_i, p_fetch_i, a_shift_i, res_push_i and done_i, each input, 1, status strobes from the FIOS multiplier.
REQ-012 SHALL have ports b_addr_o and p_addr_o, each output, clog2(s), the word index of the b and p operand RAMs.
REQ-013 SHALL have port a_cnt_o, output, clog2(s), the number of a-register shifts performed.
REQ-014 SHALL have ports res_we_o, output, 1, and res_addr_o, output, clog2(s), the result RAM write port.
REQ-015 SHALL have ports resp_valid_o, output, 1; resp_tag_o, output, TAG_W; and resp_err_o, output, 1; these form the completion response.
REQ-016 SHALL have port resp_ready_i, input, 1, the consumer accepts the response.
REQ-017 SHALL have port busy_o, output, 1, high whenever the state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, START, RUN and RESP, one-hot or binary, with no other reachable states.
REQ-019 IDLE: req_ready_o=1; on req_valid_i the sequencer SHALL latch req_tag_i and go to START.
REQ-020 START: start_o=1 for exactly this one cycle; b_addr, p_addr, a_cnt, res count and watchdog SHALL clear to 0; next state is RUN.
REQ-021 A request accepted at edge T SHALL produce start_o high in cycle T+1, i.e. one cycle of latency.
REQ-022 RUN, b_fetch_i: b_addr_o SHALL increment on the next edge and wrap s-1 -> 0; p_fetch_i SHALL act independently on p_addr_o with the same rule.
REQ-023 RUN, a_shift_i: a_cnt_o SHALL increment and saturate at s-1.
REQ-024 RUN: res_we_o SHALL be combinational res_push_i with res_addr_o = the current res count; the count SHALL increment afterwards and saturate at s; a push while the count equals s SHALL assert res_we_o=0 and set the overflow flag.
REQ-025 RUN: the watchdog SHALL increment every cycle; if it reaches TIMEOUT-1 with no done_i, the FSM SHALL go to RESP with err=1.
REQ-026 RUN, done_i: the FSM SHALL go to RESP with err = (res count after this cycle's push != s) OR overflow.
REQ-027 If res_push_i and done_i occur in the same cycle, the push SHALL be written and counted before the error check.
REQ-028 If done_i and the timeout occur in the same cycle, done_i SHALL take priority.
REQ-029 RESP: resp_valid_o=1, with resp_tag_o and resp_err_o held stable; on resp_ready_i the FSM SHALL go to IDLE.
REQ-030 Back-to-back requests: req_ready_o SHALL be 0 in the cycle of the RESP handshake, so a new request is accepted no earlier than the following IDLE cycle.
REQ-031 Strobes (b_fetch_i, p_fetch_i, a_shift_i, res_push_i, done_i) received outside RUN SHALL be ignored, with no counter change and res_we_o=0.
REQ-032 req_valid_i SHALL be ignored outside IDLE.

Reset
REQ-033 While reset_n_i=0 the sequencer SHALL hold: state IDLE, req_ready_o=1, start_o=0, busy_o=0, resp_valid_o=0, resp_err_o=0, resp_tag_o=0, all addresses and counters 0, overflow flag 0.
REQ-034 Reset asserted mid-RUN SHALL abort immediately with no response emitted; after release the FSM SHALL be in IDLE.

Verification
REQ-035 Nominal, s=8: tag 5 accepted -> start_o one cycle later; 8 pushes write addresses 0..7; done_i -> resp_valid_o=1, tag 5, err 0.
REQ-036 Wrap: 9 b_fetch_i strobes -> b_addr_o sequence 1..7, 0, 1; p_addr_o stays 0 when p_fetch_i is idle.
REQ-037 Same-cycle event: 8th res_push_i in the same cycle as done_i -> res_we_o=1 at address 7, err 0; done_i after only 7 pushes -> err 1.
REQ-038 Timeout: TIMEOUT=16, no done_i -> resp_valid_o=1 with err 1 sixteen cycles after start_o; a push in cycle 9 is still written.
REQ-039 Backpressure and reset: hold resp_ready_i=0 for 10 cycles -> response stable and req_valid_i ignored; reset_n_i low mid-RUN -> all outputs at reset values asynchronously and no response emitted.
